pre_if_stage: RTL and testbench

Pre-IF stage of the 5-stage LoongArch pipeline. It owns the fetch PC and issues instruction requests on an SRAM-like address channel (req/addr_ok). Accepted requests are handed to the IF stage with a valid/allowin handshake. It applies redirects (exception entry, ertn return, branch), detects misaligned fetch addresses (ADEF), and tells IF when an already-issued request is stale and its response must be dropped.

---
 rtl/pre_if_stage_pkg.sv | 22 ++
 rtl/pre_if_stage.sv | 129 ++++++++++++
 tb/tb_pre_if_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pre_if_stage_pkg.sv
// ============================================================================
// Module : pre_if_stage_pkg
// Brief  : Shared constants and state encoding for the pre-IF fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pre_if_stage_pkg;

    localparam int          PFS_TO_FS_BUS_WD = 49;
    localparam int          C_ADEF_BIT       = 14;
    localparam logic [31:0] C_RESET_PC       = 32'h1c00_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } pfs_state_e;

endpackage

`default_nettype wire

// File: rtl/pre_if_stage.sv
// ============================================================================
// Module : pre_if_stage
// Brief  : Owns the fetch PC, issues SRAM-like instruction requests, hands
//          accepted requests to IF, applies redirects and flags ADEF.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          ADEF_BIT = C_ADEF_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fs_allowin,
    input  logic                        br_taken,
    input  logic [31:0]                 br_target,
    input  logic                        excp_flush,
    input  logic                        ertn_flush,
    input  logic [31:0]                 eentry,
    input  logic [31:0]                 era,
    output logic                        inst_req,
    output logic                        inst_wr,
    output logic [1:0]                  inst_size,
    output logic [31:0]                 inst_addr,
    output logic [3:0]                  inst_wstrb,
    output logic [31:0]                 inst_wdata,
    input  logic                        inst_addr_ok,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        pfs_discard
);

    pfs_state_e  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_adef;
    logic        w_req;
    logic        w_hs;
    logic        w_valid;
    logic        w_excp;
    logic        w_discard;
    logic [15:0] w_excp_num;

    assign w_redirect = excp_flush | ertn_flush | br_taken;
    assign w_target   = excp_flush ? eentry :
                        ertn_flush ? era    : br_target;
    assign w_adef     = (r_pc[1:0] != 2'b00);
    assign w_hs       = w_req & inst_addr_ok;

    // A redirect blocks both the request and the hand-off in the same cycle,
    // so no stale request is ever issued from REQ.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_excp      = 1'b0;
        w_discard   = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req   = ~w_adef & ~w_redirect & ~reset;
                w_valid = (w_hs | w_adef) & ~w_redirect;
                w_excp  = w_adef;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else if (w_adef & fs_allowin) begin
                    w_state_nxt = S_HALT;
                end else if (w_hs & fs_allowin) begin
                    w_pc_nxt = r_pc + 32'd4;
                end else if (w_hs) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_valid = ~w_redirect;
                if (w_redirect) begin
                    w_discard   = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (fs_allowin) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end
            S_HALT: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_excp_num           = 16'd0;
        w_excp_num[ADEF_BIT] = w_excp;
    end

    assign inst_req        = w_req;
    assign inst_wr         = 1'b0;
    assign inst_size       = reset ? 2'd0 : 2'd2;
    assign inst_addr       = reset ? 32'd0 : r_pc;
    assign inst_wstrb      = 4'd0;
    assign inst_wdata      = 32'd0;
    assign pfs_to_fs_valid = w_valid & ~reset;
    assign pfs_to_fs_bus   = reset ? '0 : {w_excp_num, w_excp, r_pc};
    assign pfs_discard     = w_discard & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: hand-computed fetch sequences and redirects.
`default_nettype none

module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] eentry;
    logic [31:0] era;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        pfs_to_fs_valid;
    logic [48:0] pfs_to_fs_bus;
    logic        pfs_discard;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pre_if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .fs_allowin      (fs_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .excp_flush      (excp_flush),
        .ertn_flush      (ertn_flush),
        .eentry          (eentry),
        .era             (era),
        .inst_req        (inst_req),
        .inst_wr         (inst_wr),
        .inst_size       (inst_size),
        .inst_addr       (inst_addr),
        .inst_wstrb      (inst_wstrb),
        .inst_wdata      (inst_wdata),
        .inst_addr_ok    (inst_addr_ok),
        .pfs_to_fs_valid (pfs_to_fs_valid),
        .pfs_to_fs_bus   (pfs_to_fs_bus),
        .pfs_discard     (pfs_discard)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; fs_allowin = 1'b1; inst_addr_ok = 1'b1;
        br_taken = 1'b0; br_target = '0; excp_flush = 1'b0; ertn_flush = 1'b0;
        eentry = 32'h1c00_8000; era = 32'h1c00_0010;
        tick(); tick();
        #1;
        chk("rst_req",     64'(inst_req), 64'd0);
        chk("rst_valid",   64'(pfs_to_fs_valid), 64'd0);
        chk("rst_addr",    64'(inst_addr), 64'd0);
        chk("rst_discard", 64'(pfs_discard), 64'd0);

        // Full-rate streaming after reset release
        reset = 1'b0; #1;
        chk("s0_req",   64'(inst_req), 64'd1);
        chk("s0_addr",  64'(inst_addr), 64'h1c00_0000);
        chk("s0_valid", 64'(pfs_to_fs_valid), 64'd1);
        chk("s0_excp",  64'(pfs_to_fs_bus[48:32]), 64'd0);
        tick();
        chk("s1_addr",  64'(inst_addr), 64'h1c00_0004);
        chk("s1_valid", 64'(pfs_to_fs_valid), 64'd1);
        tick();
        chk("s2_addr",  64'(inst_addr), 64'h1c00_0008);

        // Back-pressure: accepted but IF not ready -> WAIT
        fs_allowin = 1'b0; #1;
        chk("bp_req",   64'(inst_req), 64'd1);
        tick();
        chk("w_req",    64'(inst_req), 64'd0);
        chk("w_valid",  64'(pfs_to_fs_valid), 64'd1);
        chk("w_pc",     64'(pfs_to_fs_bus[31:0]), 64'h1c00_0008);
        tick();
        chk("w2_valid", 64'(pfs_to_fs_valid), 64'd1);
        fs_allowin = 1'b1; #1;
        chk("w2_req",   64'(inst_req), 64'd0);
        tick();
        chk("wt_req",   64'(inst_req), 64'd1);
        chk("wt_addr",  64'(inst_addr), 64'h1c00_000c);
        tick();
        // Enter WAIT at 0x1c000010, then branch away
        fs_allowin = 1'b0;
        tick();
        br_taken = 1'b1; br_target = 32'h1c00_0100; fs_allowin = 1'b1; #1;
        chk("d_discard", 64'(pfs_discard), 64'd1);
        chk("d_valid",   64'(pfs_to_fs_valid), 64'd0);
        chk("d_req",     64'(inst_req), 64'd0);
        tick();
        br_taken = 1'b0; #1;
        chk("d1_discard", 64'(pfs_discard), 64'd0);
        chk("d1_req",     64'(inst_req), 64'd1);
        chk("d1_addr",    64'(inst_addr), 64'h1c00_0100);
        tick();

        // Exception flush and branch together: eentry wins
        excp_flush = 1'b1; br_taken = 1'b1; br_target = 32'h1c00_0200; #1;
        chk("ef_req",   64'(inst_req), 64'd0);
        chk("ef_valid", 64'(pfs_to_fs_valid), 64'd0);
        tick();
        excp_flush = 1'b0; br_taken = 1'b0; #1;
        chk("ef1_req",  64'(inst_req), 64'd1);
        chk("ef1_addr", 64'(inst_addr), 64'h1c00_8000);
        tick();

        // Misaligned branch target -> ADEF, then HALT until ertn
        br_taken = 1'b1; br_target = 32'h1c00_0102;
        tick();
        br_taken = 1'b0; #1;
        chk("ad_req",   64'(inst_req), 64'd0);
        chk("ad_valid", 64'(pfs_to_fs_valid), 64'd1);
        chk("ad_pc",    64'(pfs_to_fs_bus[31:0]), 64'h1c00_0102);
        chk("ad_excp",  64'(pfs_to_fs_bus[48:32]), 64'h0_8001);
        tick();
        chk("h_req",    64'(inst_req), 64'd0);
        chk("h_valid",  64'(pfs_to_fs_valid), 64'd0);
        tick();
        chk("h2_req",   64'(inst_req), 64'd0);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0; #1;
        chk("er_req",   64'(inst_req), 64'd1);
        chk("er_addr",  64'(inst_addr), 64'h1c00_0010);

        // Memory stalls: request held, then reset mid-request
        inst_addr_ok = 1'b0; #1;
        chk("st0_valid", 64'(pfs_to_fs_valid), 64'd0);
        tick();
        chk("st1_req",   64'(inst_req), 64'd1);
        chk("st1_addr",  64'(inst_addr), 64'h1c00_0010);
        tick();
        reset = 1'b1; #1;
        chk("st2_rst_req", 64'(inst_req), 64'd0);
        tick();
        chk("st3_rst_req", 64'(inst_req), 64'd0);
        reset = 1'b0; #1;
        chk("rr_req",   64'(inst_req), 64'd1);
        chk("rr_addr",  64'(inst_addr), 64'h1c00_0000);
        chk("rr_disc",  64'(pfs_discard), 64'd0);
        tick();

        // PC wrap at the top of the address space
        br_taken = 1'b1; br_target = 32'hffff_fffc;
        tick();
        br_taken = 1'b0; inst_addr_ok = 1'b1; #1;
        chk("wr_addr",  64'(inst_addr), 64'hffff_fffc);
        tick();
        chk("wr_zero",  64'(inst_addr), 64'd0);
        chk("wr_req",   64'(inst_req), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
